// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I(+M) decode stage.
// Holds opcodes, 6-bit ALU operation codes, operand-select codes, the
// mem-size encoding, the buffer state codes and the packed control bundle.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [5:0] ALU_LTS  = 6'b000000;
  localparam logic [5:0] ALU_LTU  = 6'b000001;
  localparam logic [5:0] ALU_SLTS = 6'b000010;
  localparam logic [5:0] ALU_SLTU = 6'b000011;
  localparam logic [5:0] ALU_GES  = 6'b001010;
  localparam logic [5:0] ALU_GEU  = 6'b001011;
  localparam logic [5:0] ALU_EQ   = 6'b001100;
  localparam logic [5:0] ALU_NE   = 6'b001101;
  localparam logic [5:0] ALU_OR   = 6'b001110;
  localparam logic [5:0] ALU_XOR  = 6'b001111;
  localparam logic [5:0] ALU_AND  = 6'b010101;
  localparam logic [5:0] ALU_ADD  = 6'b011000;
  localparam logic [5:0] ALU_SUB  = 6'b011001;
  localparam logic [5:0] ALU_SRA  = 6'b100100;
  localparam logic [5:0] ALU_SRL  = 6'b100101;
  localparam logic [5:0] ALU_SLL  = 6'b100111;
  // M ops occupy 110000..110111; low bits are funct3 (MUL..REMU)
  localparam logic [2:0] ALU_M_HI = 3'b110;

  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  localparam logic [2:0] OPB_RS2  = 3'b000;
  localparam logic [2:0] OPB_IMMI = 3'b001;
  localparam logic [2:0] OPB_IMMU = 3'b010;
  localparam logic [2:0] OPB_IMMS = 3'b011;
  localparam logic [2:0] OPB_FOUR = 3'b100;

  // mem_size is funct3 verbatim
  localparam logic [2:0] MSZ_B  = 3'b000;
  localparam logic [2:0] MSZ_H  = 3'b001;
  localparam logic [2:0] MSZ_W  = 3'b010;
  localparam logic [2:0] MSZ_BU = 3'b100;
  localparam logic [2:0] MSZ_HU = 3'b101;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  typedef struct packed {
    logic [1:0] op_a_sel;
    logic [2:0] op_b_sel;
    logic [5:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic       wb_src;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } dec_t;

  // Base integer op selected by funct3 when funct7 is zero
  function automatic logic [5:0] alu_of_f3(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_of_f3 = ALU_ADD;
      3'd1:    alu_of_f3 = ALU_SLL;
      3'd2:    alu_of_f3 = ALU_SLTS;
      3'd3:    alu_of_f3 = ALU_SLTU;
      3'd4:    alu_of_f3 = ALU_XOR;
      3'd5:    alu_of_f3 = ALU_SRL;
      3'd6:    alu_of_f3 = ALU_OR;
      default: alu_of_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word -> control bundle and
// selected sign-extended immediate.
//   instr_i : 32-bit instruction word
//   dec_o   : decoded control bundle (enables forced low when illegal)
//   imm_o   : I/S/B/U/J immediate for the format, 0 for R-type/no-ops
module riscv_decode_comb
  import riscv_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o,
  output logic [31:0] imm_o
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        illegal;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'h000};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    dec_o          = '0;
    dec_o.alu_op   = ALU_ADD;
    dec_o.mem_size = f3;
    imm_o          = '0;
    illegal        = 1'b0;
    // any opcode with [1:0] != 11 falls into default
    case (opc)
      OPC_LOAD: begin
        dec_o.op_b_sel = OPB_IMMI;
        dec_o.mem_req  = 1'b1;
        dec_o.gpr_we   = 1'b1;
        dec_o.wb_src   = 1'b1;
        imm_o          = imm_i;
        illegal        = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      OPC_STORE: begin
        dec_o.op_b_sel = OPB_IMMS;
        dec_o.mem_req  = 1'b1;
        dec_o.mem_we   = 1'b1;
        imm_o          = imm_s;
        illegal        = (f3 > 3'd2);
      end
      OPC_OP_IMM: begin
        dec_o.op_b_sel = OPB_IMMI;
        dec_o.gpr_we   = 1'b1;
        dec_o.alu_op   = alu_of_f3(f3);
        imm_o          = imm_i;
        if (f3 == 3'd1) illegal = (f7 != 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) dec_o.alu_op = ALU_SRA;
          else if (f7 != 7'h00) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec_o.gpr_we = 1'b1;
        case (f7)
          7'h00: dec_o.alu_op = alu_of_f3(f3);
          7'h20: begin
            if (f3 == 3'd0)      dec_o.alu_op = ALU_SUB;
            else if (f3 == 3'd5) dec_o.alu_op = ALU_SRA;
            else                 illegal = 1'b1;
          end
          7'h01: begin
            if (ENABLE_M) dec_o.alu_op = {ALU_M_HI, f3};
            else          illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec_o.branch = 1'b1;
        imm_o        = imm_b;
        case (f3)
          3'd0:    dec_o.alu_op = ALU_EQ;
          3'd1:    dec_o.alu_op = ALU_NE;
          3'd4:    dec_o.alu_op = ALU_LTS;
          3'd5:    dec_o.alu_op = ALU_GES;
          3'd6:    dec_o.alu_op = ALU_LTU;
          3'd7:    dec_o.alu_op = ALU_GEU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_o.op_a_sel = OPA_PC;
        dec_o.op_b_sel = OPB_FOUR;
        dec_o.gpr_we   = 1'b1;
        dec_o.jal      = 1'b1;
        imm_o          = imm_j;
      end
      OPC_JALR: begin
        dec_o.op_a_sel = OPA_PC;
        dec_o.op_b_sel = OPB_FOUR;
        dec_o.gpr_we   = 1'b1;
        dec_o.jalr     = 1'b1;
        imm_o          = imm_i;
        illegal        = (f3 != 3'd0);
      end
      OPC_LUI: begin
        dec_o.op_a_sel = OPA_ZERO;
        dec_o.op_b_sel = OPB_IMMU;
        dec_o.gpr_we   = 1'b1;
        imm_o          = imm_u;
      end
      OPC_AUIPC: begin
        dec_o.op_a_sel = OPA_PC;
        dec_o.op_b_sel = OPB_IMMU;
        dec_o.gpr_we   = 1'b1;
        imm_o          = imm_u;
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    dec_o.illegal = illegal;
    if (illegal) begin
      dec_o.mem_req = 1'b0;
      dec_o.mem_we  = 1'b0;
      dec_o.gpr_we  = 1'b0;
      dec_o.branch  = 1'b0;
      dec_o.jal     = 1'b0;
      dec_o.jalr    = 1'b0;
    end
  end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered decode stage: decodes one instruction per handshake and holds
// the result in a 2-entry skid buffer (output register + skid register),
// so instr_ready_o is a flop. Counts illegal instructions delivered.
//   clk_i, rst_i (sync, active-high), flush_i
//   instr_valid_i/instr_ready_o, instr_i, pc_i      : upstream
//   dec_valid_o/dec_ready_i, lsu_stall_req_i        : downstream
//   pc_o, imm_o, ex_*, alu_op_o, mem_*, gpr_we_a_o, wb_src_sel_o,
//   branch_o, jal_o, jalr_o, illegal_instr_o        : decoded bundle
//   illegal_cnt_o                                   : saturating count
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [PC_W-1:0]  pc_i,
  output logic             dec_valid_o,
  input  logic             dec_ready_i,
  input  logic             lsu_stall_req_i,
  input  logic             flush_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [31:0]      imm_o,
  output logic [1:0]       ex_op_a_sel_o,
  output logic [2:0]       ex_op_b_sel_o,
  output logic [5:0]       alu_op_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [2:0]       mem_size_o,
  output logic             gpr_we_a_o,
  output logic             wb_src_sel_o,
  output logic             branch_o,
  output logic             jal_o,
  output logic             jalr_o,
  output logic             illegal_instr_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  typedef struct packed {
    dec_t            dec;
    logic [31:0]     imm;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t            in_e, out_q, out_d, skid_q, skid_d;
  logic [1:0]        state_q, state_d;
  logic              ready_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy, acc, del;

  riscv_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (
    .instr_i (instr_i),
    .dec_o   (in_e.dec),
    .imm_o   (in_e.imm)
  );
  assign in_e.pc = pc_i;

  assign rdy = dec_ready_i & ~lsu_stall_req_i;
  assign acc = instr_valid_i & ready_q;
  assign del = (state_q != ST_EMPTY) & rdy;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (acc) begin out_d = in_e; state_d = ST_ONE; end
      ST_ONE: begin
        if (acc && !rdy)     begin skid_d = in_e; state_d = ST_FULL; end
        else if (acc && rdy) out_d = in_e;
        else if (rdy)        state_d = ST_EMPTY;
      end
      ST_FULL: if (rdy) begin out_d = skid_q; state_d = ST_ONE; end
      default: state_d = ST_EMPTY;
    endcase
    // flush lets this cycle's handshakes complete but drops everything held
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (del && out_q.dec.illegal && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_FULL);
      out_q   <= out_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_ready_o   = ready_q;
  assign dec_valid_o     = (state_q != ST_EMPTY);
  assign pc_o            = out_q.pc;
  assign imm_o           = out_q.imm;
  assign ex_op_a_sel_o   = out_q.dec.op_a_sel;
  assign ex_op_b_sel_o   = out_q.dec.op_b_sel;
  assign alu_op_o        = out_q.dec.alu_op;
  assign mem_req_o       = out_q.dec.mem_req;
  assign mem_we_o        = out_q.dec.mem_we;
  assign mem_size_o      = out_q.dec.mem_size;
  assign gpr_we_a_o      = out_q.dec.gpr_we;
  assign wb_src_sel_o    = out_q.dec.wb_src;
  assign branch_o        = out_q.dec.branch;
  assign jal_o           = out_q.dec.jal;
  assign jalr_o          = out_q.dec.jalr;
  assign illegal_instr_o = out_q.dec.illegal;
  assign illegal_cnt_o   = cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: two instances share stimulus,
// [0] ENABLE_M=0/CNT_W=2 and [1] ENABLE_M=1/CNT_W=16. A queue holds the
// instructions the stage should be holding; each held word is decoded by
// a reference decoder written from the ISA rules.
module tb_riscv_decode_stage;

  typedef struct packed {
    logic [1:0] a;
    logic [2:0] b;
    logic [5:0] alu;
    logic       mreq, mwe;
    logic [2:0] msz;
    logic       gwe, wbs, br, jal, jalr, ill;
  } bun_t;

  logic clk = 1'b0, rst = 1'b1, iv = 1'b0, dr = 1'b0, st = 1'b0, fl = 1'b0;
  logic [31:0] ins = '0, pc = '0;

  logic       rdy_o [2], vld_o [2], mreq_o [2], mwe_o [2], gwe_o [2], wbs_o [2];
  logic       br_o [2], jal_o [2], jalr_o [2], ill_o [2];
  logic [1:0] a_o [2];
  logic [2:0] b_o [2], msz_o [2];
  logic [5:0] alu_o [2];
  logic [31:0] pco [2], immo [2];
  logic [1:0]  cnt0;
  logic [15:0] cnt1;

  int n_chk = 0, n_pass = 0;
  logic [63:0] q[$];
  logic        m_rdy = 1'b0;
  int          m_cnt [2];

  always #5 clk = ~clk;

  riscv_decode_stage #(.ENABLE_M(1'b0), .PC_W(32), .CNT_W(2)) dut0 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(iv), .instr_ready_o(rdy_o[0]),
    .instr_i(ins), .pc_i(pc), .dec_valid_o(vld_o[0]), .dec_ready_i(dr),
    .lsu_stall_req_i(st), .flush_i(fl), .pc_o(pco[0]), .imm_o(immo[0]),
    .ex_op_a_sel_o(a_o[0]), .ex_op_b_sel_o(b_o[0]), .alu_op_o(alu_o[0]),
    .mem_req_o(mreq_o[0]), .mem_we_o(mwe_o[0]), .mem_size_o(msz_o[0]),
    .gpr_we_a_o(gwe_o[0]), .wb_src_sel_o(wbs_o[0]), .branch_o(br_o[0]),
    .jal_o(jal_o[0]), .jalr_o(jalr_o[0]), .illegal_instr_o(ill_o[0]),
    .illegal_cnt_o(cnt0));

  riscv_decode_stage #(.ENABLE_M(1'b1), .PC_W(32), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(iv), .instr_ready_o(rdy_o[1]),
    .instr_i(ins), .pc_i(pc), .dec_valid_o(vld_o[1]), .dec_ready_i(dr),
    .lsu_stall_req_i(st), .flush_i(fl), .pc_o(pco[1]), .imm_o(immo[1]),
    .ex_op_a_sel_o(a_o[1]), .ex_op_b_sel_o(b_o[1]), .alu_op_o(alu_o[1]),
    .mem_req_o(mreq_o[1]), .mem_we_o(mwe_o[1]), .mem_size_o(msz_o[1]),
    .gpr_we_a_o(gwe_o[1]), .wb_src_sel_o(wbs_o[1]), .branch_o(br_o[1]),
    .jal_o(jal_o[1]), .jalr_o(jalr_o[1]), .illegal_instr_o(ill_o[1]),
    .illegal_cnt_o(cnt1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 6'b011000; 3'd1: return 6'b100111; 3'd2: return 6'b000010;
      3'd3: return 6'b000011; 3'd4: return 6'b001111; 3'd5: return 6'b100101;
      3'd6: return 6'b001110; default: return 6'b010101;
    endcase
  endfunction

  function automatic logic [5:0] br_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 6'b001100; 3'd1: return 6'b001101; 3'd4: return 6'b000000;
      3'd5: return 6'b001010; 3'd6: return 6'b000001; default: return 6'b001011;
    endcase
  endfunction

  // Reference decode from the ISA tables; immediates via signed extension.
  function automatic bun_t ref_dec(input logic [31:0] w, input bit m, output logic [31:0] imm);
    bun_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12]; f7 = w[31:25];
    e = '0; e.alu = 6'b011000; e.msz = f3; imm = '0;
    case (w[6:0])
      7'h03: begin e.b = 3'd1; e.mreq = 1; e.gwe = 1; e.wbs = 1;
             imm = 32'($signed(w[31:20])); e.ill = (f3 == 3 || f3 > 5); end
      7'h23: begin e.b = 3'd3; e.mreq = 1; e.mwe = 1;
             imm = 32'($signed({w[31:25], w[11:7]})); e.ill = (f3 > 2); end
      7'h13: begin e.b = 3'd1; e.gwe = 1; imm = 32'($signed(w[31:20]));
             e.alu = base_op(f3);
             if (f3 == 1 && f7 != 0) e.ill = 1;
             if (f3 == 5 && f7 == 7'h20) e.alu = 6'b100100;
             else if (f3 == 5 && f7 != 0) e.ill = 1; end
      7'h33: begin e.gwe = 1;
             if (f7 == 0) e.alu = base_op(f3);
             else if (f7 == 7'h20 && f3 == 0) e.alu = 6'b011001;
             else if (f7 == 7'h20 && f3 == 5) e.alu = 6'b100100;
             else if (f7 == 7'h01 && m) e.alu = 6'd48 + 6'(f3);
             else e.ill = 1; end
      7'h63: begin e.br = 1; e.alu = br_op(f3);
             imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
             e.ill = (f3 == 2 || f3 == 3); end
      7'h6F: begin e.a = 2'd1; e.b = 3'd4; e.gwe = 1; e.jal = 1;
             imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
      7'h67: begin e.a = 2'd1; e.b = 3'd4; e.gwe = 1; e.jalr = 1;
             imm = 32'($signed(w[31:20])); e.ill = (f3 != 0); end
      7'h37: begin e.a = 2'd2; e.b = 3'd2; e.gwe = 1; imm = w & 32'hFFFFF000; end
      7'h17: begin e.a = 2'd1; e.b = 3'd2; e.gwe = 1; imm = w & 32'hFFFFF000; end
      7'h0F, 7'h73: ;
      default: e.ill = 1;
    endcase
    if (e.ill) {e.mreq, e.mwe, e.gwe, e.br, e.jal, e.jalr} = '0;
    return e;
  endfunction

  function automatic bun_t got(input int k);
    return {a_o[k], b_o[k], alu_o[k], mreq_o[k], mwe_o[k], msz_o[k],
            gwe_o[k], wbs_o[k], br_o[k], jal_o[k], jalr_o[k], ill_o[k]};
  endfunction

  task automatic check_all();
    logic [63:0] h;
    logic [31:0] ei;
    bun_t e, g;
    chk("ready0", 64'(rdy_o[0]), 64'(m_rdy));
    chk("ready1", 64'(rdy_o[1]), 64'(m_rdy));
    chk("valid0", 64'(vld_o[0]), 64'(q.size() != 0));
    chk("valid1", 64'(vld_o[1]), 64'(q.size() != 0));
    chk("cnt0", 64'(cnt0), 64'(m_cnt[0]));
    chk("cnt1", 64'(cnt1), 64'(m_cnt[1]));
    if (q.size() != 0) begin
      h = q[0];
      for (int k = 0; k < 2; k++) begin
        e = ref_dec(h[63:32], k == 1, ei);
        g = got(k);
        chk($sformatf("pc%0d", k), 64'(pco[k]), 64'(h[31:0]));
        if (e.ill)
          chk($sformatf("ill_fields%0d", k),
              64'({g.ill, g.mreq, g.mwe, g.gwe, g.br, g.jal, g.jalr}), 64'(7'b1000000));
        else begin
          chk($sformatf("bundle%0d_w%08h", k, h[63:32]), 64'(g), 64'(e));
          chk($sformatf("imm%0d", k), 64'(immo[k]), 64'(ei));
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic [31:0] p,
                      input logic d, input logic s, input logic f);
    logic [63:0] h;
    logic [31:0] ei;
    bun_t e;
    bit acc, del;
    @(negedge clk);
    rst = r; iv = v; ins = w; pc = p; dr = d; st = s; fl = f;
    acc = v && m_rdy && !r;
    del = (q.size() != 0) && d && !s && !r;
    if (r) begin
      q.delete(); m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      if (del) begin
        h = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          e = ref_dec(h[63:32], k == 1, ei);
          if (e.ill && m_cnt[k] < ((k == 0) ? 3 : 65535)) m_cnt[k]++;
        end
      end
      if (acc && !f) q.push_back({w, p});
      if (f) q.delete();
    end
    m_rdy = !r && (q.size() < 2);
    @(posedge clk); #1;
    check_all();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h03; 1: w[6:0] = 7'h23; 2: w[6:0] = 7'h13; 3: w[6:0] = 7'h33;
      4: w[6:0] = 7'h63; 5: w[6:0] = 7'h6F; 6: w[6:0] = 7'h67; 7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17; 9: w[6:0] = 7'h0F; 10: w[6:0] = 7'h73; default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; 2: w[31:25] = 7'h01; default: ;
    endcase
    return w;
  endfunction

  initial begin
    int exp_c [6];
    exp_c = '{0, 1, 2, 3, 3, 3};
    m_cnt[0] = 0; m_cnt[1] = 0;

    repeat (3) step(1, 0, 0, 0, 1, 0, 0);
    chk("rst_pc", 64'(pco[0]), 64'(0));
    chk("rst_imm", 64'(immo[0]), 64'(0));
    chk("rst_alu", 64'(alu_o[0]), 64'(0));
    chk("rst_gwe", 64'(gwe_o[1]), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("rdy_after_rst", 64'(rdy_o[0]), 64'(1));

    step(0, 1, 32'h002081B3, 32'h100, 1, 0, 0);
    chk("add_alu", 64'(alu_o[1]), 64'(6'b011000));
    chk("add_gwe", 64'(gwe_o[1]), 64'(1));
    chk("add_bsel", 64'(b_o[1]), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 1, 32'h0000A103, 32'h104, 0, 0, 0);
    step(0, 1, 32'h0020A023, 32'h108, 0, 0, 0);
    step(0, 1, 32'h002081B3, 32'h10C, 0, 0, 0);
    chk("full_rdy", 64'(rdy_o[0]), 64'(0));
    chk("lw_we", 64'(mwe_o[0]), 64'(0));
    chk("lw_size", 64'(msz_o[0]), 64'(3'b010));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("sw_we", 64'(mwe_o[0]), 64'(1));
    chk("sw_pc", 64'(pco[0]), 64'(32'h108));
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 1, 32'h022081B3, 32'h200, 1, 0, 0);
    chk("mul_alu_m", 64'(alu_o[1]), 64'(6'b110000));
    chk("mul_ill_nom", 64'(ill_o[0]), 64'(1));
    chk("mul_gwe_nom", 64'(gwe_o[0]), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("mul_cnt_nom", 64'(cnt0), 64'(1));
    chk("mul_cnt_m", 64'(cnt1), 64'(0));

    step(0, 1, 32'h002081B3, 32'h300, 0, 0, 0);
    step(0, 1, 32'h0000A103, 32'h304, 0, 0, 0);
    step(0, 1, 32'h0020A023, 32'h308, 0, 0, 1);
    chk("flush_vld", 64'(vld_o[0]), 64'(0));
    chk("flush_rdy", 64'(rdy_o[0]), 64'(1));
    repeat (3) step(0, 0, 0, 0, 1, 0, 0);

    step(0, 1, 32'hFF9FF0EF, 32'h400, 1, 0, 0);
    chk("jal_imm", 64'(immo[1]), 64'(32'hFFFFFFF8));
    chk("jal_flag", 64'(jal_o[1]), 64'(1));
    chk("jal_asel", 64'(a_o[1]), 64'(2'b01));
    chk("jal_bsel", 64'(b_o[1]), 64'(3'b100));
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 1, 32'h0, 32'h500, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("midrst_vld", 64'(vld_o[0]), 64'(0));
    chk("midrst_cnt", 64'(cnt0), 64'(0));
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, i < 5, 32'h0, 32'(i * 4), 1, 0, 0);
      chk($sformatf("sat_cnt%0d", i), 64'(cnt0), 64'(exp_c[i]));
    end
    chk("nosat_cnt", 64'(cnt1), 64'(5));

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rnd_instr(), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Registered RISC-V RV32I(+M) decode stage between instruction fetch and execute. It accepts one instruction word plus its PC per valid/ready handshake and decodes it into the existing ALU/LSU/register-file control bundle. The decoded bundle is held in a 2-entry skid buffer, so `instr_ready_o` is registered. The stage adds flush, an optional M extension, immediate generation and a saturating illegal-instruction counter.

## Interface
- `ENABLE_M`, default 0: 1 = decode MUL/DIV/REM group; 0 = these encodings are illegal.
- `PC_W`, default 32: PC width carried through the stage.
- `CNT_W`, default 16: width of the illegal-instruction counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `instr_valid_i` / `instr_ready_o` in/out 1: upstream handshake.
- `instr_i` in 32, `pc_i` in PC_W: fetched word and its PC.
- `dec_valid_o` out 1 / `dec_ready_i` in 1: downstream handshake.
- `lsu_stall_req_i` in 1: when 1, downstream is treated as not ready.
- `flush_i` in 1: discard every held entry and any incoming instruction this cycle.
- `pc_o` out PC_W, `imm_o` out 32: registered PC and selected sign-extended immediate (I/S/B/U/J).
- `ex_op_a_sel_o` out 2, `ex_op_b_sel_o` out 3, `alu_op_o` out 6: operand selects and ALU operation.
- `mem_req_o`, `mem_we_o` out 1, `mem_size_o` out 3: LSU controls.
- `gpr_we_a_o`, `wb_src_sel_o` out 1: register-file controls.
- `branch_o`, `jal_o`, `jalr_o` out 1: control-flow flags.
- `illegal_instr_o` out 1: decoded instruction is illegal.
- `illegal_cnt_o` out CNT_W: count of illegal instructions delivered downstream.

## Operation
- **Operand a select:** 00 = rs1, 01 = PC, 10 = zero.
- **Operand b select:** 000 = rs2, 001 = ImmI, 010 = ImmU, 011 = ImmS, 100 = constant 4.
- **wb_src_sel:** 0 = ALU result, 1 = LSU result.
- **mem_size_o:** equals funct3. Loads are legal for funct3 0,1,2,4,5; stores for 0,1,2.
- **RegReg / RegImm:** funct3/funct7 map to ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - SLTU is 000011 in both formats.
  - RegImm shifts require funct7 = 0x00, or 0x20 for SRAI.
- **Branch:** BEQ, BNE, BLT, BGE, BLTU, BGEU map to comparison ops with `branch_o`=1. funct3 2 and 3 are illegal.
- **Jumps:**
  - JAL: a=PC, b=4, `jal_o`=1, imm = ImmJ.
  - JALR: legal only for funct3=0; a=PC, b=4, `jalr_o`=1, imm = ImmI.
- **LUI / AUIPC:** LUI uses a=zero, b=ImmU; AUIPC uses a=PC, b=ImmU.
- **MISC-MEM, SYSTEM:** legal no-ops; every enable is 0.
- **M extension:** RegReg with funct7=0x01 decodes MUL..REMU to 6'b110000 + funct3 when ENABLE_M=1, and is illegal otherwise.
- **Illegal instructions:** an unknown opcode, opcode[1:0]≠11, or any illegal field combination sets `illegal_instr_o`=1. It also forces `mem_req_o`, `mem_we_o`, `gpr_we_a_o`, `branch_o`, `jal_o` and `jalr_o` to 0. The other fields are don't-care.
- **Buffer states:**
  - EMPTY: output not valid.
  - ONE: output register valid.
  - FULL: output and skid both valid.
  - `instr_ready_o` = (state≠FULL), registered.
  - Effective downstream ready: rdy = `dec_ready_i` & ~`lsu_stall_req_i`.
- **Transitions:**
  - EMPTY + accept → ONE.
  - ONE + accept & ~rdy → FULL; the new entry goes to skid.
  - ONE + accept & rdy → ONE; the output is replaced.
  - ONE + ~accept & rdy → EMPTY.
  - FULL + rdy → ONE; skid moves to output.
  - FULL never accepts.
- **Counter:** `illegal_cnt_o` increments when `dec_valid_o`&rdy&`illegal_instr_o`. It saturates at 2^CNT_W−1 and is not cleared by flush.

## Timing
- Latency: 1 cycle from an accepted instruction (EMPTY state) to `dec_valid_o`.
- Throughput: 1 instruction/cycle while rdy=1.
- Output bundle is stable while `dec_valid_o`=1 and rdy=0.
- **Reset values:**
  - State EMPTY; `dec_valid_o`=0.
  - `instr_ready_o`=0 during reset and 1 in the first cycle after reset.
  - All decoded outputs, `pc_o`, `imm_o` and `illegal_cnt_o` are 0.
- **Reset mid-operation:** both entries are dropped and the counter is cleared.
- **flush_i:**
  - Next state is EMPTY regardless of other inputs.
  - A same-cycle upstream handshake completes, but the instruction is discarded.
  - A same-cycle downstream handshake does complete.
  - An illegal instruction delivered in a flush cycle is still counted.
- A simultaneous accept and deliver in ONE keeps the state at ONE with no bubble.

## Structure
- **Package `riscv_pkg`:**
  - Opcode localparams.
  - 6-bit ALU op codes, including M ops 110000–110111.
  - Operand-select codes and the mem-size encoding.
  - Packed decoded-bundle typedef.
- **Sub-module `riscv_decode_comb`:** purely combinational instruction → bundle + immediate. It is instantiated once, and the stage wraps it in the skid buffer.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with rdy=1 → next cycle `dec_valid_o`=1, `alu_op_o`=011000, `gpr_we_a_o`=1, `ex_op_b_sel_o`=000.
- Back-to-back `lw` (0x0000A103), `sw` (0x0020A023) with `dec_ready_i` low for 3 cycles → state FULL, `instr_ready_o`=0, order preserved. `mem_size_o`=010 for both; `mem_we_o` 0 then 1.
- `mul` (0x022081B3): ENABLE_M=1 → `alu_op_o`=110000. ENABLE_M=0 → `illegal_instr_o`=1, `gpr_we_a_o`=0, `illegal_cnt_o` +1.
- `flush_i` in FULL with `instr_valid_i`=1 → next cycle `dec_valid_o`=0, `instr_ready_o`=1, neither entry is ever delivered.
- `jal x1,-8` (0xFF9FF0EF) → `imm_o`=0xFFFFFFF8, `jal_o`=1, a=01, b=100.
- CNT_W=2 with 5 illegal words (0x00000000) → counter reads 1,2,3,3,3.
